alu_op_sequencer: RTL and testbench

Sequences operation commands into the shared 6-bit ALU, which includes the Set_Value clear/set unit. Requesters push {sel, A, B, acc} commands through a valid/ready port into a small command FIFO. The block drives the ALU operand/select lines, waits a fixed settle time, captures the ALU result and presents it on a valid/ready result port. The last captured result is kept in an accumulator so chained operations can use it as the A operand.

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_op_sequencer_if.sv | 28 ++
 rtl/alu_cmd_fifo.sv | 53 +++++
 rtl/alu_op_sequencer.sv | 147 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU widths, select codes and sequencer state encoding
package alu_pkg;

    localparam int ALU_W     = 6;
    localparam int ALU_SEL_W = 4;

    localparam logic [ALU_SEL_W-1:0] SEL_CLEAR = 4'b0000;
    localparam logic [ALU_SEL_W-1:0] SEL_SET   = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLD    = 2'd3
    } seq_state_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// rtl/alu_op_sequencer_if.sv - command and result handshake bundle of the ALU sequencer
interface alu_op_sequencer_if
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W,
    parameter int SEL_W = ALU_SEL_W
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [SEL_W-1:0] cmd_sel;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             cmd_acc;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;

    modport slave (
        input  cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_acc, res_ready,
        output cmd_ready, res_valid, res_data
    );

    modport master (
        output cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_acc, res_ready,
        input  cmd_ready, res_valid, res_data
    );

endinterface

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - synchronous command FIFO, wrap detected via pointer MSB
module alu_cmd_fifo #(
    parameter int DW    = 17,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [DW-1:0]            wdata_i,
    input  logic                     pop_i,
    output logic [DW-1:0]            rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - queues ALU commands, drives the ALU, captures and returns results
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH         = ALU_W,
    parameter int SEL_W         = ALU_SEL_W,
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_op_sequencer_if.slave   bus,
    output logic [SEL_W-1:0]    alu_sel,
    output logic [WIDTH-1:0]    alu_a,
    output logic [WIDTH-1:0]    alu_b,
    input  logic [WIDTH-1:0]    alu_x,
    output logic                busy
);

    localparam int EW = SEL_W + 2 * WIDTH + 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

    seq_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [SEL_W-1:0] alu_sel_q, alu_sel_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [AW:0]      fifo_count;
    logic [EW-1:0]    head;
    logic [SEL_W-1:0] head_sel;
    logic [WIDTH-1:0] head_a;
    logic [WIDTH-1:0] head_b;
    logic             head_acc;

    assign push          = bus.cmd_valid && !fifo_full;
    assign bus.cmd_ready = !fifo_full;
    assign {head_sel, head_a, head_b, head_acc} = head;

    alu_cmd_fifo #(
        .DW    (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i ({bus.cmd_sel, bus.cmd_a, bus.cmd_b, bus.cmd_acc}),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_sel_d   = alu_sel_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        acc_d       = acc_q;
        pop         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                pop = !fifo_empty;
            end
            ST_ISSUE: begin
                // alu_x is sampled exactly once, on the edge leaving the settle window.
                if (cnt_q == CNT_LAST) begin
                    res_data_d = alu_x;
                    state_d    = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_CAPTURE: begin
                acc_d       = res_data_q;
                res_valid_d = 1'b1;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    if (fifo_empty) begin
                        state_d = ST_IDLE;
                    end else begin
                        pop = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Pops only happen after CAPTURE, so acc_q already holds the previous result.
        if (pop) begin
            state_d   = ST_ISSUE;
            cnt_d     = '0;
            alu_sel_d = head_sel;
            alu_a_d   = head_acc ? acc_q : head_a;
            alu_b_d   = head_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            alu_sel_q   <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            acc_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_sel_q   <= alu_sel_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            acc_q       <= acc_d;
        end
    end

    assign alu_sel       = alu_sel_q;
    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign busy          = (fifo_count != '0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - randomized self-checking bench with ALU and accumulator reference model
module tb_alu_op_sequencer;
    import alu_pkg::*;

    localparam int W  = ALU_W;
    localparam int SW = ALU_SEL_W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [SW-1:0] alu_sel;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [W-1:0]  alu_x;
    logic          busy;

    int            errors = 0;
    int            checks = 0;
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  model_acc = '0;
    bit            accepted = 1'b0;

    alu_op_sequencer_if #(.WIDTH(W), .SEL_W(SW)) bus ();

    alu_op_sequencer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .alu_sel (alu_sel),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_x   (alu_x),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for the shared ALU, including the clear/set unit.
    function automatic logic [W-1:0] alu_f(input logic [SW-1:0] s, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        case (s)
            SEL_CLEAR: return '0;
            SEL_SET:   return '1;
            4'd1:      return a + b;
            4'd2:      return a - b;
            4'd3:      return a & b;
            4'd4:      return a | b;
            4'd5:      return a ^ b;
            4'd6:      return ~a;
            4'd7:      return b;
            default:   return {a[W-2:0], b[W-1]};
        endcase
    endfunction

    assign alu_x = alu_f(alu_sel, alu_a, alu_b);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with inputs set; observes the coming edge and returns at the next negedge.
    task automatic step();
        #1;
        accepted = 1'b0;
        if (!rst_n) begin
            exp_q.delete();
            model_acc = '0;
        end else begin
            if (bus.cmd_valid && bus.cmd_ready) begin
                model_acc = alu_f(bus.cmd_sel, bus.cmd_acc ? model_acc : bus.cmd_a, bus.cmd_b);
                exp_q.push_back(model_acc);
                accepted = 1'b1;
            end
            if (bus.res_valid && bus.res_ready) begin
                if (exp_q.size() == 0) chk("res_unexpected", 32'd1, 32'd0);
                else chk("res_data", 32'(bus.res_data), 32'(exp_q.pop_front()));
            end
        end
        @(negedge clk);
    endtask

    task automatic set_cmd(input logic v, input logic [SW-1:0] s, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic ac);
        bus.cmd_valid = v;
        bus.cmd_sel   = s;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_acc   = ac;
    endtask

    task automatic send(input logic [SW-1:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ac);
        int n = 0;
        set_cmd(1'b1, s, a, b, ac);
        do begin
            step();
            n++;
        end while (!accepted && n < 50);
        if (!accepted) chk("send_timeout", 32'd0, 32'd1);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_res();
        int n = 0;
        while (!bus.res_valid && n < 30) begin
            step();
            n++;
        end
        if (!bus.res_valid) chk("wait_res_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        while ((exp_q.size() != 0 || busy) && n < 200) begin
            step();
            n++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int lat;
        int n;
        int n_acc;
        logic [SW-1:0] s;
        logic [W-1:0]  a;
        logic [W-1:0]  b;

        set_cmd(1'b0, '0, '0, '0, 1'b0);
        bus.res_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        repeat (3) step();
        rst_n = 1'b1;

        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res_data", 32'(bus.res_data), 32'd0);
        chk("rst_alu", 32'({alu_sel, alu_a, alu_b}), 32'd0);

        // Single SET with an always-ready consumer
        bus.res_ready = 1'b1;
        send(SEL_SET, 6'h05, 6'h0A, 1'b0);
        lat = 0;
        while (!bus.res_valid && lat < 20) begin
            step();
            lat++;
        end
        chk("set_latency", 32'(lat), 32'd3);
        chk("set_data", 32'(bus.res_data), 32'h3F);
        step();
        chk("set_busy_after", 32'(busy), 32'd0);

        // Accumulator chain queued back to back
        send(SEL_SET, 6'h12, 6'h00, 1'b0);
        send(SEL_CLEAR, 6'h15, 6'h2A, 1'b1);
        n = 0;
        while (alu_sel != SEL_CLEAR && n < 20) begin
            step();
            n++;
        end
        chk("chain_alu_a", 32'(alu_a), 32'h3F);
        drain();

        // Full FIFO: one command in flight plus four queued
        bus.res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(SW'($urandom), W'($urandom), W'($urandom), 1'($urandom));
        end
        chk("full_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        set_cmd(1'b1, SW'($urandom), W'($urandom), W'($urandom), 1'($urandom));
        repeat (3) begin
            step();
            chk("full_no_accept", 32'(accepted), 32'd0);
        end
        bus.res_ready = 1'b1;
        n = 0;
        while (!accepted && n < 50) begin
            step();
            n++;
        end
        chk("full_sixth_accepted", 32'(accepted), 32'd1);
        drain();

        // Backpressure: result and ALU drive must hold while the consumer stalls
        bus.res_ready = 1'b0;
        s = 4'd5;
        a = W'($urandom);
        b = W'($urandom);
        send(s, a, b, 1'b0);
        wait_res();
        repeat (10) begin
            step();
            chk("bp_valid", 32'(bus.res_valid), 32'd1);
            chk("bp_data", 32'(bus.res_data), 32'(a ^ b));
            chk("bp_alu", 32'({alu_sel, alu_a, alu_b}), 32'({s, a, b}));
        end
        drain();

        // Reset while ISSUE is active with three commands still queued
        bus.res_ready = 1'b0;
        send(4'd1, W'($urandom), W'($urandom), 1'b0);
        wait_res();
        for (int i = 0; i < 4; i++) begin
            send(SW'($urandom), W'($urandom), W'($urandom), 1'b0);
        end
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        rst_n = 1'b0;
        set_cmd(1'b1, SEL_SET, 6'h01, 6'h02, 1'b0);
        step();
        rst_n = 1'b1;
        bus.cmd_valid = 1'b0;
        chk("rstmid_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        bus.res_ready = 1'b1;
        repeat (8) begin
            step();
            chk("rstmid_no_stale", 32'(bus.res_valid), 32'd0);
        end
        bus.res_ready = 1'b0;
        send(4'd1, W'($urandom), 6'h05, 1'b1);
        wait_res();
        chk("rstmid_acc", 32'(bus.res_data), 32'h05);
        drain();

        // Random traffic against the reference model
        n_acc = 0;
        n = 0;
        bus.cmd_valid = 1'b0;
        while (n_acc < 1000 && n < 30000) begin
            if (!(bus.cmd_valid && !accepted)) begin
                set_cmd(1'($urandom_range(0, 9) < 7), SW'($urandom), W'($urandom),
                        W'($urandom), 1'($urandom));
            end
            bus.res_ready = 1'($urandom_range(0, 9) < 6);
            step();
            if (accepted) n_acc++;
            n++;
        end
        chk("rand_count", 32'(n_acc), 32'd1000);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
